ps2_receiver: RTL

- Receive-only PS/2 keyboard front end for the CPU's keyboard interrupt path.
- Synchronizes and filters the raw ps2_clk/ps2_data pins and deserializes 11-bit device-to-host frames.
- Buffers validated scan codes in a small FIFO.
- Presents the head entry to the interrupt scheduler using a data_ready / active-low read-strobe (rdn) handshake.
- Scan codes are passed through raw; E0/F0 prefixes are not interpreted.

---
 rtl/ps2_receiver_if.sv | 34 +++
 rtl/ps2_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver_if.sv
// ps2_receiver_if
//   Scheduler-facing bus of the PS/2 keyboard receiver.
//   slave  : the receiver (drives ready/scan code/status, samples rdn)
//   master : the interrupt scheduler (drives rdn, samples the rest)
// Signals:
//   ps2_rdn         active-low read strobe, one pop per low cycle
//   ps2_data_ready  FIFO non-empty
//   ps2_scan_code   FIFO head entry
//   ps2_err_parity  one-cycle pulse, frame dropped for bad parity
//   ps2_err_frame   one-cycle pulse, frame dropped for bad stop bit / timeout
//   ps2_overflow    one-cycle pulse, valid frame dropped on a full FIFO
//   ps2_fifo_count  number of stored entries
`timescale 1ns/1ps
interface ps2_receiver_if;
  logic       ps2_rdn;
  logic       ps2_data_ready;
  logic [7:0] ps2_scan_code;
  logic       ps2_err_parity;
  logic       ps2_err_frame;
  logic       ps2_overflow;
  logic [4:0] ps2_fifo_count;

  modport slave (
    input  ps2_rdn,
    output ps2_data_ready, ps2_scan_code, ps2_err_parity,
           ps2_err_frame, ps2_overflow, ps2_fifo_count
  );

  modport master (
    output ps2_rdn,
    input  ps2_data_ready, ps2_scan_code, ps2_err_parity,
           ps2_err_frame, ps2_overflow, ps2_fifo_count
  );
endinterface

// File: rtl/ps2_receiver.sv
// ps2_receiver
//   Receive-only PS/2 keyboard front end. Synchronizes and glitch-filters the
//   raw PS/2 pins, deserializes 11-bit device-to-host frames (start, 8 data
//   LSB first, odd parity, stop), buffers good scan codes in a FIFO and
//   presents the head to the interrupt scheduler.
// Ports:
//   schi_clk   system clock
//   schi_rst   asynchronous active-low reset
//   ps2_clk    raw PS/2 clock pin (idles high)
//   ps2_data   raw PS/2 data pin (idles high)
//   bus        scheduler handshake/status bus (ps2_receiver_if.slave)
`timescale 1ns/1ps
module ps2_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic          schi_clk,
  input  logic          schi_rst,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  ps2_receiver_if.slave bus
);
  localparam int              AW        = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              FW        = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]   FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [15:0]     TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]      DEPTH5    = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Synchronizers, clock filter and falling-edge strobe
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall;

  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_fall   <= 1'b0;
      // Count consecutive samples disagreeing with the filtered level; the
      // filtered clock only follows once FILTER_LEN of them are seen in a row.
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= r_filt_clk;  // strobe only on the 1->0 change
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame deserializer
  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic [15:0] r_to_cnt;
  logic        r_err_par, r_err_frm;
  logic        w_par_ok, w_push;

  assign w_par_ok = ^{r_shift, r_par};
  // The stop-bit strobe of a good frame writes the FIFO on the same edge.
  assign w_push   = r_fall && (r_state == S_STOP) && w_par_ok && r_dat_s2;

  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_err_par <= 1'b0;
      r_err_frm <= 1'b0;
    end else begin
      r_err_par <= 1'b0;
      r_err_frm <= 1'b0;
      if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
        if (r_fall && !r_dat_s2) begin
          r_state   <= S_DATA;
          r_bit_cnt <= '0;
        end
      end else if (r_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_DATA: begin
            r_shift   <= {r_dat_s2, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= S_STOP;
          end
          default: begin
            // Parity is judged first; a bad stop bit is only reported when
            // parity was good.
            if (!w_par_ok)      r_err_par <= 1'b1;
            else if (!r_dat_s2) r_err_frm <= 1'b1;
            r_state <= S_IDLE;
          end
        endcase
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt  <= '0;
        r_err_frm <= 1'b1;
        r_state   <= S_IDLE;
      end else begin
        r_to_cnt <= r_to_cnt + 16'd1;
      end
    end
  end

  // Scan-code FIFO with registered head
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [4:0]    r_count;
  logic          r_ready, r_ovf;
  logic [7:0]    r_head;
  logic          w_pop, w_full, w_wr;
  logic [4:0]    w_count_nxt;
  logic [AW-1:0] w_rptr_nxt;
  logic [7:0]    w_head_nxt;

  assign w_pop       = !bus.ps2_rdn && (r_count != 5'd0);
  assign w_full      = (r_count == DEPTH5);
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_count_nxt = r_count + 5'(w_wr) - 5'(w_pop);
  assign w_rptr_nxt  = r_rptr + AW'(w_pop);

  always_comb begin
    w_head_nxt = r_head;
    if (w_count_nxt != 5'd0) begin
      // When the only surviving entry is the one being written this edge,
      // it comes straight from the shift register.
      if ((r_count == 5'd0) || (w_pop && (r_count == 5'd1))) w_head_nxt = r_shift;
      else if (w_pop)                                         w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge schi_clk or negedge schi_rst) begin
    if (!schi_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b0;
      r_head  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr) r_mem[r_wptr] <= r_shift;
      r_wptr  <= r_wptr + AW'(w_wr);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 5'd0);
      r_head  <= w_head_nxt;
      r_ovf   <= w_push && w_full && !w_pop;
    end
  end

  assign bus.ps2_data_ready = r_ready;
  assign bus.ps2_scan_code  = r_head;
  assign bus.ps2_err_parity = r_err_par;
  assign bus.ps2_err_frame  = r_err_frm;
  assign bus.ps2_overflow   = r_ovf;
  assign bus.ps2_fifo_count = r_count;
endmodule
